// File: rtl/sim_pkg.sv
// rtl/sim_pkg.sv - shared coordinate format and scheduler state encoding
package sim_pkg;

    localparam int W    = 32;
    localparam int FRAC = 16;

    typedef logic signed [W-1:0] q16_16_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/pos_regfile.sv
// rtl/pos_regfile.sv - chain position storage, one write port, up/self/down and readback ports
module pos_regfile #(
    parameter int NODES = 8,
    parameter int W     = 32,
    parameter int AW    = $clog2(NODES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wx,
    input  logic [W-1:0]  wy,
    input  logic [AW-1:0] up_idx,
    input  logic [AW-1:0] self_idx,
    input  logic [AW-1:0] down_idx,
    input  logic [AW-1:0] rd_idx,
    output logic [W-1:0]  up_x,
    output logic [W-1:0]  up_y,
    output logic [W-1:0]  self_x,
    output logic [W-1:0]  self_y,
    output logic [W-1:0]  down_x,
    output logic [W-1:0]  down_y,
    output logic [W-1:0]  rd_x,
    output logic [W-1:0]  rd_y
);

    logic [W-1:0] pos_x [NODES];
    logic [W-1:0] pos_y [NODES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODES; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
            end
        end else if (we) begin
            pos_x[waddr] <= wx;
            pos_y[waddr] <= wy;
        end
    end

    assign up_x   = pos_x[up_idx];
    assign up_y   = pos_y[up_idx];
    assign self_x = pos_x[self_idx];
    assign self_y = pos_y[self_idx];
    assign down_x = pos_x[down_idx];
    assign down_y = pos_y[down_idx];
    assign rd_x   = pos_x[rd_idx];
    assign rd_y   = pos_y[rd_idx];

endmodule

// File: rtl/constraint_scheduler.sv
// rtl/constraint_scheduler.sv - Gauss-Seidel sequencer feeding one shared constraint unit
module constraint_scheduler #(
    parameter int NODES = 8,
    parameter int ITERS = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     load_en,
    input  logic [$clog2(NODES)-1:0] load_idx,
    input  logic [W-1:0]             load_x,
    input  logic [W-1:0]             load_y,
    input  logic [$clog2(NODES)-1:0] rd_idx,
    output logic [W-1:0]             rd_x,
    output logic [W-1:0]             rd_y,
    output logic [W-1:0]             ec_up_x,
    output logic [W-1:0]             ec_up_y,
    output logic [W-1:0]             ec_x,
    output logic [W-1:0]             ec_y,
    output logic [W-1:0]             ec_down_x,
    output logic [W-1:0]             ec_down_y,
    output logic                     ec_is_last,
    input  logic [W-1:0]             ec_x_enf,
    input  logic [W-1:0]             ec_y_enf
);
    import sim_pkg::sched_state_t;
    import sim_pkg::ST_IDLE;
    import sim_pkg::ST_FETCH;
    import sim_pkg::ST_WRITE;
    import sim_pkg::ST_DONE;

    localparam int AW  = $clog2(NODES);
    localparam int ITW = (ITERS > 1) ? $clog2(ITERS) : 1;

    sched_state_t   state;
    logic [AW-1:0]  idx;
    logic [ITW-1:0] iter;

    logic           idx_last;
    logic [AW-1:0]  up_idx;
    logic [AW-1:0]  down_idx;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [W-1:0]   wx, wy;
    logic [W-1:0]   up_x, up_y, self_x, self_y, down_x, down_y;

    assign idx_last = (idx == AW'(NODES - 1));
    assign up_idx   = idx - AW'(1);
    // The last node has no lower neighbour, so it sees itself as "down".
    assign down_idx = idx_last ? idx : idx + AW'(1);

    // Loads only land in IDLE; in WRITE the enforced result owns the port.
    assign we    = (state == ST_WRITE) || ((state == ST_IDLE) && load_en);
    assign waddr = (state == ST_WRITE) ? idx      : load_idx;
    assign wx    = (state == ST_WRITE) ? ec_x_enf : load_x;
    assign wy    = (state == ST_WRITE) ? ec_y_enf : load_y;

    assign busy = (state != ST_IDLE);

    pos_regfile #(
        .NODES (NODES),
        .W     (W),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wx       (wx),
        .wy       (wy),
        .up_idx   (up_idx),
        .self_idx (idx),
        .down_idx (down_idx),
        .rd_idx   (rd_idx),
        .up_x     (up_x),
        .up_y     (up_y),
        .self_x   (self_x),
        .self_y   (self_y),
        .down_x   (down_x),
        .down_y   (down_y),
        .rd_x     (rd_x),
        .rd_y     (rd_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= AW'(1);
            iter       <= '0;
            done       <= 1'b0;
            ec_up_x    <= '0;
            ec_up_y    <= '0;
            ec_x       <= '0;
            ec_y       <= '0;
            ec_down_x  <= '0;
            ec_down_y  <= '0;
            ec_is_last <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FETCH;
                        idx   <= AW'(1);
                        iter  <= '0;
                    end
                end
                ST_FETCH: begin
                    ec_up_x    <= up_x;
                    ec_up_y    <= up_y;
                    ec_x       <= self_x;
                    ec_y       <= self_y;
                    ec_down_x  <= down_x;
                    ec_down_y  <= down_y;
                    ec_is_last <= idx_last;
                    state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (!idx_last) begin
                        idx   <= idx + AW'(1);
                        state <= ST_FETCH;
                    end else if (iter != ITW'(ITERS - 1)) begin
                        iter  <= iter + ITW'(1);
                        idx   <= AW'(1);
                        state <= ST_FETCH;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_constraint_scheduler.sv
// tb/tb_constraint_scheduler.sv - two-instance bench (ITERS=1 and ITERS=3) with stub constraint unit
module tb_constraint_scheduler;

    logic clk;
    logic rst_n;

    logic        start    [2];
    logic        load_en  [2];
    logic [1:0]  load_idx [2];
    logic [31:0] load_x   [2];
    logic [31:0] load_y   [2];
    logic [1:0]  rd_idx   [2];
    logic        busy     [2];
    logic        done     [2];
    logic [31:0] rd_x     [2];
    logic [31:0] rd_y     [2];
    logic [31:0] ec_up_x  [2];
    logic [31:0] ec_up_y  [2];
    logic [31:0] ec_x     [2];
    logic [31:0] ec_y     [2];
    logic [31:0] ec_down_x[2];
    logic [31:0] ec_down_y[2];
    logic        ec_is_last[2];
    logic [31:0] enf_x    [2];
    logic [31:0] enf_y    [2];

    int total = 0;
    int bad   = 0;

    int          m_t [2];
    logic [31:0] m_x [2][3];
    logic [31:0] m_y [2][3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign enf_x[g] = ec_x[g] + 32'd1;
        assign enf_y[g] = ec_y[g] + 32'd2;

        constraint_scheduler #(
            .NODES (3),
            .ITERS ((g == 0) ? 1 : 3),
            .W     (32)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .load_en    (load_en[g]),
            .load_idx   (load_idx[g]),
            .load_x     (load_x[g]),
            .load_y     (load_y[g]),
            .rd_idx     (rd_idx[g]),
            .rd_x       (rd_x[g]),
            .rd_y       (rd_y[g]),
            .ec_up_x    (ec_up_x[g]),
            .ec_up_y    (ec_up_y[g]),
            .ec_x       (ec_x[g]),
            .ec_y       (ec_y[g]),
            .ec_down_x  (ec_down_x[g]),
            .ec_down_y  (ec_down_y[g]),
            .ec_is_last (ec_is_last[g]),
            .ec_x_enf   (enf_x[g]),
            .ec_y_enf   (enf_y[g])
        );
    end

    function automatic int run_len(input int d);
        return 2 * 2 * ((d == 0) ? 1 : 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each run is a list of node updates in Gauss-Seidel order; update k lands at the
    // edge ending cycle 2k+1 after the accepting edge, and the run ends with done at cycle 2K.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_t[d] = -1;
                for (int n = 0; n < 3; n++) begin
                    m_x[d][n] = '0;
                    m_y[d][n] = '0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_t[d] < 0) begin
                    if (load_en[d]) begin
                        m_x[d][load_idx[d]] = load_x[d];
                        m_y[d][load_idx[d]] = load_y[d];
                    end
                    if (start[d]) m_t[d] = 0;
                end else begin
                    if (m_t[d] % 2 == 1) begin
                        int node;
                        node = 1 + ((m_t[d] - 1) / 2) % 2;
                        m_x[d][node] = m_x[d][node] + 32'd1;
                        m_y[d][node] = m_y[d][node] + 32'd2;
                    end
                    if (m_t[d] == run_len(d)) m_t[d] = -1;
                    else m_t[d] = m_t[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy[%0d]", d), busy[d], m_t[d] >= 0);
            chk($sformatf("done[%0d]", d), done[d], m_t[d] == run_len(d));
            chk($sformatf("rd_x[%0d]", d), rd_x[d], m_x[d][rd_idx[d]]);
            chk($sformatf("rd_y[%0d]", d), rd_y[d], m_y[d][rd_idx[d]]);
            if (m_t[d] >= 0 && m_t[d] % 2 == 1) begin
                int node;
                node = 1 + ((m_t[d] - 1) / 2) % 2;
                chk($sformatf("up_x[%0d]", d), ec_up_x[d], m_x[d][node-1]);
                chk($sformatf("up_y[%0d]", d), ec_up_y[d], m_y[d][node-1]);
                chk($sformatf("self_x[%0d]", d), ec_x[d], m_x[d][node]);
                chk($sformatf("self_y[%0d]", d), ec_y[d], m_y[d][node]);
                chk($sformatf("down_x[%0d]", d), ec_down_x[d], m_x[d][(node == 2) ? 2 : node + 1]);
                chk($sformatf("down_y[%0d]", d), ec_down_y[d], m_y[d][(node == 2) ? 2 : node + 1]);
                chk($sformatf("is_last[%0d]", d), ec_is_last[d], node == 2);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) rd_idx[d] = (rd_idx[d] == 2'd2) ? 2'd0 : rd_idx[d] + 2'd1;
    endtask

    task automatic rd_chk(input int d, input int n, input logic [31:0] ex, input logic [31:0] ey);
        rd_idx[d] = n[1:0];
        #1;
        chk($sformatf("lit_rd_x[%0d][%0d]", d, n), rd_x[d], ex);
        chk($sformatf("lit_rd_y[%0d][%0d]", d, n), rd_y[d], ey);
    endtask

    task automatic load_node(input int d, input int n, input logic [31:0] x, input logic [31:0] y);
        load_en[d]  = 1'b1;
        load_idx[d] = n[1:0];
        load_x[d]   = x;
        load_y[d]   = y;
        tick();
        load_en[d]  = 1'b0;
    endtask

    task automatic load_chain(input int d);
        load_node(d, 0, 32'h0000_0000, 32'h000c_8000);
        load_node(d, 1, 32'h000c_8000, 32'h0000_a4cd);
        load_node(d, 2, 32'h000c_8000, 32'h0001_44cd);
    endtask

    task automatic kick(input int d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    // Called in the first cycle after the accepting edge; n = edges until done is seen.
    task automatic wait_done(input int d, output int n);
        n = 0;
        while (done[d] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk($sformatf("done_timeout[%0d]", d), 32'd0, 32'd1);
    endtask

    task automatic reset_state_chk(input int d);
        chk("rst_busy", busy[d], 1'b0);
        chk("rst_done", done[d], 1'b0);
        chk("rst_up_x", ec_up_x[d], 32'd0);
        chk("rst_up_y", ec_up_y[d], 32'd0);
        chk("rst_x", ec_x[d], 32'd0);
        chk("rst_y", ec_y[d], 32'd0);
        chk("rst_down_x", ec_down_x[d], 32'd0);
        chk("rst_down_y", ec_down_y[d], 32'd0);
        chk("rst_is_last", ec_is_last[d], 1'b0);
        for (int n = 0; n < 3; n++) rd_chk(d, n, 32'd0, 32'd0);
    endtask

    initial begin
        int n;
        int dc;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; load_en[d] = 0; load_idx[d] = 0;
            load_x[d] = 0; load_y[d] = 0; rd_idx[d] = 0;
        end
        tick(); tick();
        reset_state_chk(0);
        reset_state_chk(1);
        rst_n = 1'b1;
        tick();

        // ITERS=1 run with operand checks on both FETCHes
        load_chain(0);
        kick(0);
        tick();
        chk("f1_is_last", ec_is_last[0], 1'b0);
        chk("f1_down_x", ec_down_x[0], 32'h000c_8000);
        chk("f1_down_y", ec_down_y[0], 32'h0001_44cd);
        tick(); tick();
        chk("f2_up_x", ec_up_x[0], 32'h000c_8001);
        chk("f2_up_y", ec_up_y[0], 32'h0000_a4cf);
        chk("f2_down_x", ec_down_x[0], 32'h000c_8000);
        chk("f2_down_y", ec_down_y[0], 32'h0001_44cd);
        chk("f2_is_last", ec_is_last[0], 1'b1);
        tick();
        chk("done_at_4", done[0], 1'b1);
        tick();
        rd_chk(0, 0, 32'h0000_0000, 32'h000c_8000);
        rd_chk(0, 1, 32'h000c_8001, 32'h0000_a4cf);
        rd_chk(0, 2, 32'h000c_8001, 32'h0001_44cf);

        // ITERS=3 run
        load_chain(1);
        kick(1);
        wait_done(1, n);
        chk("done_lat_iters3", n, 32'd12);
        tick();
        rd_chk(1, 2, 32'h000c_8003, 32'h0001_44d3);
        rd_chk(1, 1, 32'h000c_8003, 32'h0000_a4d3);

        // start and load pulsed mid-run are ignored
        kick(1);
        tick(); tick(); tick();
        start[1] = 1'b1; load_en[1] = 1'b1; load_idx[1] = 2'd1;
        load_x[1] = 32'hdead_beef; load_y[1] = 32'hcafe_f00d;
        tick();
        start[1] = 1'b0; load_en[1] = 1'b0;
        dc = 0;
        for (int i = 0; i < 30; i++) begin
            if (done[1] === 1'b1) dc++;
            tick();
        end
        chk("single_done", dc, 32'd1);
        rd_chk(1, 1, 32'h000c_8006, 32'h0000_a4d9);
        rd_chk(1, 2, 32'h000c_8006, 32'h0001_44d9);

        // reset during WRITE of node 2
        kick(0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        reset_state_chk(0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        start[0] = 1'b1; load_en[0] = 1'b1; load_idx[0] = 2'd2;
        load_x[0] = 32'h0000_0100; load_y[0] = 32'h0000_0200;
        tick();
        start[0] = 1'b0; load_en[0] = 1'b0;
        wait_done(0, n);
        chk("done_lat_after_rst", n, 32'd4);
        tick();
        rd_chk(0, 0, 32'h0000_0000, 32'h0000_0000);
        rd_chk(0, 1, 32'h0000_0001, 32'h0000_0002);
        rd_chk(0, 2, 32'h0000_0101, 32'h0000_0202);

        // back-to-back runs
        load_chain(0);
        kick(0);
        wait_done(0, n);
        tick();
        kick(0);
        wait_done(0, n);
        chk("done_lat_b2b", n, 32'd4);
        tick();
        rd_chk(0, 1, 32'h000c_8002, 32'h0000_a4d1);
        rd_chk(0, 2, 32'h000c_8002, 32'h0001_44d1);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
